// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control FSM for a multicycle MIPS datapath in which instruction memory,
// data memory and the ALU are shared across cycles. Each instruction is
// sequenced through fetch, decode, execute, memory and writeback steps. The
// FSM drives every datapath enable and mux select, the ALU operation and the
// immediate-extension mode.
//
// Supported: R-type (add/sub/and/or/slt), lw, sw, beq, bne, addi, andi, ori,
//            slti, j.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-low reset
//   op, funct  : opcode and funct fields from the instruction register
//   zero       : ALU zero flag, same cycle
//   mem_ready  : memory access complete; FSM holds in FETCH/MEMRD/MEMWR while low
//   iord       : memory address select (0 = PC, 1 = ALUOut)
//   memwrite   : data memory write strobe
//   irwrite    : instruction register load enable
//   regdst     : register write address (0 = rt, 1 = rd)
//   memtoreg   : register write data (0 = ALUOut, 1 = memory data)
//   regwrite   : register file write enable
//   alusrca    : ALU A (0 = PC, 1 = register A)
//   alusrcb    : ALU B (00 = B, 01 = 4, 10 = ext imm, 11 = ext imm << 2)
//   pcsrc      : PC source (00 = ALU result, 01 = ALUOut, 10 = jump target)
//   pcen       : combined PC write enable
//   alucontrol : 010 add, 110 sub, 000 and, 001 or, 111 slt
//   immext     : 0 = sign-extend, 1 = zero-extend
//   illegal    : one-cycle pulse in DECODE on an unsupported opcode/funct
//   state_dbg  : current state encoding
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter logic [2:0] FETCH_PC_INC = 3'b010
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol,
    output logic       immext,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_BNEEX   = 4'd9,
        S_IMMEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_JEX     = 4'd12
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic       w_funct_ok;
    logic [2:0] w_funct_alu;
    logic       w_zext;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next_state;
    end

    // andi/ori zero-extend; op is stable in the IR from DECODE to writeback.
    assign w_zext = (op == OP_ANDI) || (op == OP_ORI);

    // R-type funct decode.
    // NOTE: every signal written in an always_comb block gets a default first,
    // so no path through the case statements can infer a latch.
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_alu = FETCH_PC_INC;
        case (funct)
            6'b100000: w_funct_alu = FETCH_PC_INC;
            6'b100010: w_funct_alu = ALU_SUB;
            6'b100100: w_funct_alu = ALU_AND;
            6'b100101: w_funct_alu = ALU_OR;
            6'b101010: w_funct_alu = ALU_SLT;
            default:   w_funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        iord         = 1'b0;
        memwrite     = 1'b0;
        irwrite      = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        pcen         = 1'b0;
        alucontrol   = FETCH_PC_INC;
        immext       = 1'b0;
        illegal      = 1'b0;

        case (r_state)
            S_FETCH: begin
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite      = 1'b1;
                    pcen         = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target PC + (imm << 2) is parked in ALUOut here.
                alusrcb = 2'b11;
                immext  = w_zext;
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE: begin
                        w_next_state = S_RTYPEEX;
                        illegal      = ~w_funct_ok;
                    end
                    OP_BEQ:  w_next_state = S_BEQEX;
                    OP_BNE:  w_next_state = S_BNEEX;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next_state = S_IMMEX;
                    OP_J:    w_next_state = S_JEX;
                    default: begin
                        w_next_state = S_FETCH;
                        illegal      = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca      = 1'b1;
                alusrcb      = 2'b10;
                w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                // Strobe stays up for every stall cycle until memory accepts.
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) w_next_state = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca      = 1'b1;
                alucontrol   = w_funct_alu;
                w_next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst       = 1'b1;
                regwrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca      = 1'b1;
                alucontrol   = ALU_SUB;
                pcsrc        = 2'b01;
                pcen         = (r_state == S_BEQEX) ? zero : ~zero;
                w_next_state = S_FETCH;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                immext  = w_zext;
                case (op)
                    OP_SLTI: alucontrol = ALU_SLT;
                    OP_ANDI: alucontrol = ALU_AND;
                    OP_ORI:  alucontrol = ALU_OR;
                    default: alucontrol = FETCH_PC_INC;
                endcase
                w_next_state = S_IMMWB;
            end
            S_IMMWB: begin
                immext       = w_zext;
                regwrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JEX: begin
                pcsrc        = 2'b10;
                pcen         = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase

        // While reset is held the state is FETCH, but mem_ready could still
        // raise irwrite/pcen combinationally; suppress every strobe.
        if (!reset) begin
            irwrite  = 1'b0;
            pcen     = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign state_dbg = r_state;

endmodule
